// File: rtl/xor_implies_stream.sv
// Streams an N-bit vector in W-bit beats, then evaluates parity AND K implication terms.
// Define XOR_IMPLIES_DIAG_EN to add the out_viol violated-implication count output.
module xor_implies_stream #(
  parameter int N = 16,
  parameter int W = 4,
  parameter int K = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out,
  output logic         out_parity
`ifdef XOR_IMPLIES_DIAG_EN
  ,
  output logic [(($clog2(K+1) > 0) ? $clog2(K+1) : 1)-1:0] out_viol
`endif
);

  localparam int B  = N / W;
  localparam int CW = (B > 1) ? $clog2(B) : 1;

  typedef enum logic [1:0] {COLLECT, EVAL, DONE} state_t;

  state_t        state, state_nxt;
  logic [N-1:0]  vec;
  logic [CW-1:0] beat_cnt;
  logic          run_parity;
  logic          beat_fire;
  logic          last_beat;
  logic          implies_ok;

  assign beat_fire = (state == COLLECT) && in_valid;
  assign last_beat = (beat_cnt == CW'(B - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) state <= COLLECT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      COLLECT: if (beat_fire && last_beat) state_nxt = EVAL;
      EVAL:    state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = COLLECT;
      default: state_nxt = COLLECT;
    endcase
  end

  always_comb begin
    in_ready  = (state == COLLECT);
    out_valid = (state == DONE);
  end

  // The running parity is cleared only when a result is consumed, so a new vector always starts from zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vec        <= '0;
      beat_cnt   <= '0;
      run_parity <= 1'b0;
    end else if (beat_fire) begin
      vec[int'(beat_cnt)*W +: W] <= in_data;
      run_parity                 <= run_parity ^ (^in_data);
      beat_cnt                   <= last_beat ? '0 : beat_cnt + CW'(1);
    end else if ((state == DONE) && out_ready) begin
      run_parity <= 1'b0;
    end
  end

  always_comb begin
    implies_ok = 1'b1;
    for (int j = 0; j < K; j++) begin
      implies_ok = implies_ok & (~vec[j] | vec[N-1-j]);
    end
  end

  // out takes its parity from the stored vector; both sources hold the same XOR once EVAL is reached.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out        <= 1'b0;
      out_parity <= 1'b0;
    end else if (state == EVAL) begin
      out        <= (^vec) & implies_ok;
      out_parity <= run_parity;
    end
  end

`ifdef XOR_IMPLIES_DIAG_EN
  localparam int VW = ($clog2(K+1) > 0) ? $clog2(K+1) : 1;

  logic [VW-1:0] viol_cnt;

  always_comb begin
    viol_cnt = '0;
    for (int j = 0; j < K; j++) begin
      viol_cnt = viol_cnt + VW'(vec[j] & ~vec[N-1-j]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)             out_viol <= '0;
    else if (state == EVAL) out_viol <= viol_cnt;
  end
`endif

endmodule

// File: tb/tb_xor_implies_stream.sv
// Scoreboard bench for xor_implies_stream: stimulus pushes expected results, a monitor pops them
// on each output handshake. out_viol is checked only when XOR_IMPLIES_DIAG_EN is defined.
module tb_xor_implies_stream;

  localparam int N  = 16;
  localparam int W  = 4;
  localparam int K  = 4;
  localparam int B  = N / W;
  localparam int VW = ($clog2(K+1) > 0) ? $clog2(K+1) : 1;

  typedef struct packed {
    logic       o;
    logic       p;
    logic [7:0] v;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic         out;
  logic         out_parity;
`ifdef XOR_IMPLIES_DIAG_EN
  logic [VW-1:0] out_viol;
`endif

  int   n_checks = 0;
  int   n_fails  = 0;
  int   rdy_mode = 0;
  exp_t exp_q[$];

  logic [N-1:0] dir_vec [7] = '{16'h0000, 16'h8000, 16'h0001, 16'h8001, 16'h000F, 16'hF00F, 16'hF01F};
  exp_t         dir_exp [7] = '{'{1'b0, 1'b0, 8'd0}, '{1'b1, 1'b1, 8'd0}, '{1'b0, 1'b1, 8'd1},
                                '{1'b0, 1'b0, 8'd0}, '{1'b0, 1'b0, 8'd4}, '{1'b0, 1'b0, 8'd0},
                                '{1'b1, 1'b1, 8'd0}};

  xor_implies_stream #(.N(N), .W(W), .K(K)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out        (out),
    .out_parity (out_parity)
`ifdef XOR_IMPLIES_DIAG_EN
    ,
    .out_viol   (out_viol)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic timeoutFail(input string name);
    n_checks++;
    n_fails++;
    $display("[TB] FAIL %s: timed out, no DUT response at %0t", name, $time);
  endtask

  // Reference: out is the vector parity, forced low by any implication i_j -> i_{N-1-j} that is broken.
  function automatic exp_t refModel(input logic [N-1:0] v);
    exp_t e;
    int   ones = 0;
    int   viol = 0;
    for (int i = 0; i < N; i++) ones += int'(v[i]);
    for (int j = 0; j < K; j++) if (v[j] == 1'b1 && v[N-1-j] == 1'b0) viol++;
    e.p = ((ones % 2) == 1);
    e.o = e.p && (viol == 0);
    e.v = 8'(viol);
    return e;
  endfunction

  // Sends nbeats beats of vec with idle gaps; entered and left just after a rising edge.
  task automatic applyStimulus(input logic [N-1:0] vec, input int min_gap, input int max_gap,
                               input int nbeats, input bit push, input exp_t e);
    bit accepted;
    for (int b = 0; b < nbeats; b++) begin
      int gap = int'($urandom_range(max_gap, min_gap));
      in_valid = 1'b0;
      repeat (gap) begin
        in_data = W'($urandom);
        @(posedge clk);
        #1;
      end
      in_valid = 1'b1;
      in_data  = vec[b*W +: W];
      accepted = 1'b0;
      for (int t = 0; t < 50 && !accepted; t++) begin
        @(negedge clk);
        accepted = in_ready;
        @(posedge clk);
        #1;
      end
      if (!accepted) timeoutFail("beat_accept");
    end
    in_valid = 1'b0;
    in_data  = W'($urandom);
    if (push && nbeats == B) begin
      exp_q.push_back(e);
      checkOutput("eval_out_valid", int'(out_valid), 0);
      checkOutput("eval_in_ready", int'(in_ready), 0);
      @(posedge clk);
      #1;
      checkOutput("latency_out_valid", int'(out_valid), 1);
    end
  endtask

  task automatic drainQueue();
    int t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      timeoutFail("drain_results");
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       out_ready = 1'($urandom_range(0, 1));
        1:       out_ready = 1'b0;
        default: out_ready = 1'b1;
      endcase
    end
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_result", int'(out_valid), 0);
      end else begin
        e = exp_q.pop_front();
        checkOutput("out", int'(out), int'(e.o));
        checkOutput("out_parity", int'(out_parity), int'(e.p));
`ifdef XOR_IMPLIES_DIAG_EN
        checkOutput("out_viol", int'(out_viol), int'(e.v));
`endif
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [N-1:0] v;

    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    checkOutput("reset_in_ready", int'(in_ready), 1);
    checkOutput("reset_out_valid", int'(out_valid), 0);
    checkOutput("reset_out", int'(out), 0);
    checkOutput("reset_out_parity", int'(out_parity), 0);
`ifdef XOR_IMPLIES_DIAG_EN
    checkOutput("reset_out_viol", int'(out_viol), 0);
`endif

    for (int i = 0; i < 7; i++) applyStimulus(dir_vec[i], 0, 2, B, 1'b1, dir_exp[i]);

    // Held result with idle gaps between beats and a stalled consumer.
    drainQueue();
    @(negedge clk);
    rdy_mode = 1;
    @(posedge clk);
    #1;
    applyStimulus(16'h8000, 3, 3, B, 1'b1, '{1'b1, 1'b1, 8'd0});
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checkOutput("hold_out_valid", int'(out_valid), 1);
      checkOutput("hold_in_ready", int'(in_ready), 0);
      checkOutput("hold_out", int'(out), 1);
      checkOutput("hold_out_parity", int'(out_parity), 1);
    end
    rdy_mode = 2;
    @(negedge clk);
    @(negedge clk);
    checkOutput("release_in_ready", int'(in_ready), 1);
    checkOutput("release_out_valid", int'(out_valid), 0);
    rdy_mode = 0;
    @(posedge clk);
    #1;

    // Abort a partial vector with reset; only the following full vector may produce a result.
    drainQueue();
    applyStimulus(16'h0001, 0, 0, 2, 1'b0, '{1'b0, 1'b0, 8'd0});
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    checkOutput("abort_in_ready", int'(in_ready), 1);
    checkOutput("abort_out_valid", int'(out_valid), 0);
    checkOutput("abort_out", int'(out), 0);
    checkOutput("abort_out_parity", int'(out_parity), 0);
    applyStimulus(16'h8000, 0, 1, B, 1'b1, '{1'b1, 1'b1, 8'd0});

    for (int n = 0; n < 40; n++) begin
      v = N'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        for (int j = 0; j < K; j++) if (v[j]) v[N-1-j] = 1'b1;
      end
      applyStimulus(v, 0, 2, B, 1'b1, refModel(v));
    end

    drainQueue();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/xor_implies_stream.md
XOR_IMPLIES_STREAM -- requirements
Module: xor_implies_stream

Interface
REQ-001 SHALL have parameter N, default 16, meaning total formula inputs i_0..i_{N-1}; legal range N>=2.
REQ-002 SHALL have parameter W, default 4, meaning beat width in bits; N mod W = 0; beats per vector B=N/W.
REQ-003 SHALL have parameter K, default 4, meaning number of implication terms; legal range 0<=K<=N/2.
REQ-004 SHALL have port clk  input  1  rising-edge clock, the only clock.
REQ-005 SHALL have port rst_n  input  1  synchronous active-low reset.
REQ-006 SHALL have port in_valid  input  1  beat valid.
REQ-007 SHALL have port in_ready  output  1  beat accepted when in_valid&in_ready at a clk edge.
REQ-008 SHALL have port in_data  input  W  beat b carries in_data[j]=i_{b*W+j}.
REQ-009 SHALL have port out_valid  output  1  result available.
REQ-010 SHALL have port out_ready  input  1  result consumed when out_valid&out_ready at a clk edge.
REQ-011 SHALL have port out  output  1  formula value.
REQ-012 SHALL have port out_parity  output  1  XOR of i_0..i_{N-1}.

Function
REQ-013 SHALL evaluate out = (i_0^...^i_{N-1}) & AND over j=0..K-1 of (~i_j | i_{N-1-j}); K=0 gives out=parity.
REQ-014 SHALL implement FSM COLLECT -> EVAL -> DONE -> COLLECT.
REQ-015 COLLECT: in_ready=1, out_valid=0; each accepted beat stored in the N-bit vector register at position beat_cnt*W and folded into a running parity; beat_cnt increments 0..B-1.
REQ-016 COLLECT: in_valid=0 leaves vector, parity and beat_cnt unchanged (arbitrary idle gaps allowed).
REQ-017 Acceptance of beat B-1 SHALL move to EVAL and clear beat_cnt to 0 (wrap).
REQ-018 EVAL: lasts exactly one cycle, in_ready=0, out_valid=0; out and out_parity registered at the edge ending EVAL.
REQ-019 Latency: last beat accepted at edge E -> out_valid=1 after edge E+1 (one EVAL cycle).
REQ-020 DONE: in_ready=0, out_valid=1; out/out_parity held stable while out_ready=0 for any number of cycles.
REQ-021 DONE with out_ready=1 SHALL return to COLLECT at that edge, clear running parity; a new beat is not accepted in that same cycle (in_ready=0 in DONE).
REQ-022 B=1 case: every accepted beat is the last beat; throughput one vector per 3 cycles.
REQ-023 in_data and in_valid SHALL be ignored outside COLLECT; out_ready ignored outside DONE.

Reset
REQ-024 rst_n=0 at an edge SHALL force state=COLLECT, beat_cnt=0, running parity=0, vector=0, out=0, out_parity=0, out_valid=0; in_ready=1 from the first edge with rst_n=1.
REQ-025 Reset mid-COLLECT, in EVAL or in DONE SHALL discard the partial vector/pending result with no output handshake.

Configuration
REQ-026 Macro XOR_IMPLIES_DIAG_EN defined: SHALL add output port out_viol, width clog2(K+1) (minimum 1), count of implication terms with i_j=1 and i_{N-1-j}=0, registered and held with out; reset value 0.
REQ-027 Macro XOR_IMPLIES_DIAG_EN undefined: out_viol port and its logic SHALL not exist; all other behaviour identical.

Verification (N=16, W=4, K=4, DIAG enabled)
REQ-028 Beats 0x0,0x0,0x0,0x0 -> out=0, out_parity=0, out_viol=0, out_valid after edge E+1.
REQ-029 Vector 0x8000 (beats 0,0,0,8) -> out=1, out_parity=1, out_viol=0; vector 0x0001 -> out=0, out_parity=1, out_viol=1; vector 0x8001 -> out=0, out_parity=0, out_viol=0.
REQ-030 Vector 0x000F -> out=0, out_parity=0, out_viol=4; vector 0xF00F -> out_parity=0, out_viol=0, out=0; vector 0xF01F -> out=1.
REQ-031 Vector 0x8000 with idle gaps of 3 cycles between beats and out_ready=0 for 5 cycles -> result unchanged, out_valid=1 and in_ready=0 throughout, back to COLLECT on the out_ready=1 edge.
REQ-032 rst_n=0 for one cycle after 2 beats of 0x0001, then full vector 0x8000 -> out=1, out_viol=0 (no residue of aborted vector), and no out_valid from the aborted vector.
